// File: rtl/tawas_raccoon_pkg.sv
// Shared Raccoon ring definitions: packet field positions, responder FSM
// encoding and the pending-access record used by the target node.
package tawas_raccoon_pkg;

  localparam int RACC_W       = 79;
  localparam int RACC_VLD     = 78;
  localparam int RACC_WR      = 77;
  localparam int RACC_ACK     = 76;
  localparam int RACC_ID_HI   = 75;
  localparam int RACC_ID_LO   = 68;
  localparam int RACC_MASK_HI = 67;
  localparam int RACC_MASK_LO = 64;
  localparam int RACC_DATA_HI = 63;
  localparam int RACC_DATA_LO = 32;
  localparam int RACC_ADDR_HI = 31;
  localparam int RACC_ADDR_LO = 0;

  localparam logic [31:0] RACC_ERR_DATA = 32'hDEAD_BEEF;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ACCESS  = 2'd1,
    ST_RESPOND = 2'd2
  } racc_state_t;

  typedef struct packed {
    logic        wr;
    logic [7:0]  id;
    logic [3:0]  mask;
    logic [31:0] data;
    logic [31:0] addr;
  } racc_pend_t;

endpackage

// File: rtl/raccoon_target_if.sv
// Local memory/register port between the Raccoon target (master) and its
// SRAM or register-file slave.
interface raccoon_target_if;
  logic        MEM_REQ;
  logic        MEM_WR;
  logic [31:0] MEM_ADDR;
  logic [3:0]  MEM_MASK;
  logic [31:0] MEM_WDATA;
  logic        MEM_ACK;
  logic [31:0] MEM_RDATA;

  modport master (
    output MEM_REQ, MEM_WR, MEM_ADDR, MEM_MASK, MEM_WDATA,
    input  MEM_ACK, MEM_RDATA
  );

  modport slave (
    input  MEM_REQ, MEM_WR, MEM_ADDR, MEM_MASK, MEM_WDATA,
    output MEM_ACK, MEM_RDATA
  );
endinterface

// File: rtl/raccoon_target.sv
// Raccoon ring responder: claims in-window requests, performs one local access
// and injects the ack response; optional access timeout via RACCOON_TIMEOUT_EN.
module raccoon_target
  import tawas_raccoon_pkg::*;
#(
  parameter logic [31:0] ADDR_BASE = 32'h0000_0000,
  parameter logic [31:0] ADDR_MASK = 32'hFFFF_0000,
  parameter logic [7:0]  TIMEOUT   = 8'd64
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic [RACC_W-1:0] RaccIn,
  output logic [RACC_W-1:0] RaccOut,
  raccoon_target_if.master  mem
);

  logic [RACC_W-1:0] racc_in;
  logic [RACC_W-1:0] out_nxt;
  racc_state_t       state, state_nxt;
  racc_pend_t        pend, pend_nxt;
  logic              req, req_nxt;
  logic              in_vld, in_ack, in_hit, claim;
  logic              tmo_hit;

  assign in_vld = racc_in[RACC_VLD];
  assign in_ack = racc_in[RACC_ACK];
  assign in_hit = (racc_in[RACC_ADDR_HI:RACC_ADDR_LO] & ADDR_MASK) == ADDR_BASE;
  assign claim  = in_vld & ~in_ack & in_hit & (state == ST_IDLE);

`ifdef RACCOON_TIMEOUT_EN
  logic [7:0] tmo_cnt;

  // Counter sits at zero outside ACCESS, so it is clear on every entry.
  always_ff @(posedge CLK) begin
    if (RST || state != ST_ACCESS) tmo_cnt <= '0;
    else                           tmo_cnt <= tmo_cnt + 8'd1;
  end

  assign tmo_hit = (tmo_cnt == TIMEOUT - 8'd1);
`else
  logic unused_timeout;
  assign unused_timeout = ^TIMEOUT;
  assign tmo_hit        = 1'b0;
`endif

  always_ff @(posedge CLK) begin
    if (RST) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    pend_nxt  = pend;
    req_nxt   = req;
    out_nxt   = racc_in;
    unique case (state)
      ST_IDLE: begin
        if (claim) begin
          state_nxt     = ST_ACCESS;
          req_nxt       = 1'b1;
          out_nxt       = '0;
          pend_nxt.wr   = racc_in[RACC_WR];
          pend_nxt.id   = racc_in[RACC_ID_HI:RACC_ID_LO];
          pend_nxt.mask = racc_in[RACC_MASK_HI:RACC_MASK_LO];
          pend_nxt.data = racc_in[RACC_DATA_HI:RACC_DATA_LO];
          pend_nxt.addr = racc_in[RACC_ADDR_HI:RACC_ADDR_LO];
        end
      end
      ST_ACCESS: begin
        if (mem.MEM_ACK) begin
          state_nxt = ST_RESPOND;
          req_nxt   = 1'b0;
          if (!pend.wr) pend_nxt.data = mem.MEM_RDATA;
        end else if (tmo_hit) begin
          state_nxt     = ST_RESPOND;
          req_nxt       = 1'b0;
          pend_nxt.data = RACC_ERR_DATA;
        end
      end
      ST_RESPOND: begin
        // Forwarded traffic owns the slot; inject only into an empty one.
        if (!in_vld) begin
          state_nxt = ST_IDLE;
          out_nxt   = {1'b1, pend.wr, 1'b1, pend.id, pend.mask, pend.data, pend.addr};
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Ring input register, slot output register and local-port state.
  always_ff @(posedge CLK) begin
    if (RST) begin
      racc_in <= '0;
      RaccOut <= '0;
      pend    <= '0;
      req     <= 1'b0;
    end else begin
      racc_in <= RaccIn;
      RaccOut <= out_nxt;
      pend    <= pend_nxt;
      req     <= req_nxt;
    end
  end

  assign mem.MEM_REQ   = req;
  assign mem.MEM_WR    = pend.wr;
  assign mem.MEM_ADDR  = pend.addr;
  assign mem.MEM_MASK  = pend.mask;
  assign mem.MEM_WDATA = pend.data;

endmodule

// File: tb/tb_raccoon_target.sv
// Directed bench for raccoon_target; the timeout scenario runs only when
// RACCOON_TIMEOUT_EN is defined for both bench and design.
module tb_raccoon_target;
  import tawas_raccoon_pkg::*;

  logic              CLK = 1'b0;
  logic              RST;
  logic [RACC_W-1:0] RaccIn;
  logic [RACC_W-1:0] RaccOut;
  int                tests_run = 0;
  int                tests_failed = 0;

  raccoon_target_if mem_if ();

  raccoon_target #(
    .ADDR_BASE(32'h0000_0000),
    .ADDR_MASK(32'hFFFF_0000),
    .TIMEOUT  (8'd4)
  ) dut (
    .CLK    (CLK),
    .RST    (RST),
    .RaccIn (RaccIn),
    .RaccOut(RaccOut),
    .mem    (mem_if.master)
  );

  always #5 CLK = ~CLK;

  function automatic logic [RACC_W-1:0] pkt(input logic vld, input logic wr, input logic ack,
                                            input logic [7:0] id, input logic [3:0] mask,
                                            input logic [31:0] data, input logic [31:0] addr);
    return {vld, wr, ack, id, mask, data, addr};
  endfunction

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic test_reset();
    RST = 1'b1;
    step();
    step();
    tests_run++;
    if (RaccOut !== '0) begin
      tests_failed++;
      $display("FAIL reset_raccout got %h want 0", RaccOut);
    end
    tests_run++;
    if ({mem_if.MEM_REQ, mem_if.MEM_WR, mem_if.MEM_ADDR, mem_if.MEM_MASK, mem_if.MEM_WDATA} !== '0) begin
      tests_failed++;
      $display("FAIL reset_mem got req=%b wr=%b addr=%h mask=%h wdata=%h want all 0",
               mem_if.MEM_REQ, mem_if.MEM_WR, mem_if.MEM_ADDR, mem_if.MEM_MASK, mem_if.MEM_WDATA);
    end
    RST = 1'b0;
    step();
  endtask

  task automatic test_read_hit();
    RaccIn = pkt(1, 0, 0, 8'h05, 4'hF, 32'h0, 32'h0000_0010);
    step();
    RaccIn = '0;
    step();
    tests_run++;
    if ({mem_if.MEM_REQ, mem_if.MEM_WR, mem_if.MEM_ADDR} !== {1'b1, 1'b0, 32'h0000_0010}) begin
      tests_failed++;
      $display("FAIL read_req got req=%b wr=%b addr=%h want req=1 wr=0 addr=00000010",
               mem_if.MEM_REQ, mem_if.MEM_WR, mem_if.MEM_ADDR);
    end
    tests_run++;
    if (RaccOut !== '0) begin
      tests_failed++;
      $display("FAIL read_slot_consumed got %h want 0", RaccOut);
    end
    mem_if.MEM_ACK   = 1'b1;
    mem_if.MEM_RDATA = 32'h1234_5678;
    step();
    mem_if.MEM_ACK = 1'b0;
    tests_run++;
    if (mem_if.MEM_REQ !== 1'b0) begin
      tests_failed++;
      $display("FAIL read_req_drop got %b want 0", mem_if.MEM_REQ);
    end
    step();
    tests_run++;
    if (RaccOut !== pkt(1, 0, 1, 8'h05, 4'hF, 32'h1234_5678, 32'h0000_0010)) begin
      tests_failed++;
      $display("FAIL read_resp got %h want %h", RaccOut,
               pkt(1, 0, 1, 8'h05, 4'hF, 32'h1234_5678, 32'h0000_0010));
    end
    step();
    tests_run++;
    if (RaccOut !== '0) begin
      tests_failed++;
      $display("FAIL read_resp_once got %h want 0", RaccOut);
    end
  endtask

  task automatic test_write_hit();
    RaccIn = pkt(1, 1, 0, 8'h07, 4'b0011, 32'hAAAA_5555, 32'h0000_0024);
    step();
    RaccIn = '0;
    step();
    tests_run++;
    if ({mem_if.MEM_REQ, mem_if.MEM_WR, mem_if.MEM_MASK, mem_if.MEM_WDATA, mem_if.MEM_ADDR}
        !== {1'b1, 1'b1, 4'h3, 32'hAAAA_5555, 32'h0000_0024}) begin
      tests_failed++;
      $display("FAIL write_req got req=%b wr=%b mask=%h wdata=%h addr=%h want 1 1 3 aaaa5555 00000024",
               mem_if.MEM_REQ, mem_if.MEM_WR, mem_if.MEM_MASK, mem_if.MEM_WDATA, mem_if.MEM_ADDR);
    end
    step();
    tests_run++;
    if ({mem_if.MEM_REQ, mem_if.MEM_WDATA} !== {1'b1, 32'hAAAA_5555}) begin
      tests_failed++;
      $display("FAIL write_req_held got req=%b wdata=%h want 1 aaaa5555", mem_if.MEM_REQ, mem_if.MEM_WDATA);
    end
    mem_if.MEM_ACK   = 1'b1;
    mem_if.MEM_RDATA = 32'hFFFF_FFFF;
    step();
    mem_if.MEM_ACK = 1'b0;
    step();
    tests_run++;
    if (RaccOut !== pkt(1, 1, 1, 8'h07, 4'b0011, 32'hAAAA_5555, 32'h0000_0024)) begin
      tests_failed++;
      $display("FAIL write_resp got %h want %h", RaccOut,
               pkt(1, 1, 1, 8'h07, 4'b0011, 32'hAAAA_5555, 32'h0000_0024));
    end
    step();
  endtask

  task automatic test_passthrough();
    logic [RACC_W-1:0] p1, p2;
    p1 = pkt(1, 0, 0, 8'h09, 4'hF, 32'h0, 32'h0001_0000);
    p2 = pkt(1, 0, 1, 8'h0A, 4'hF, 32'hCAFE_F00D, 32'h0000_0010);
    RaccIn = p1;
    step();
    RaccIn = p2;
    step();
    tests_run++;
    if ({RaccOut, mem_if.MEM_REQ} !== {p1, 1'b0}) begin
      tests_failed++;
      $display("FAIL pass_out_of_window got out=%h req=%b want out=%h req=0", RaccOut, mem_if.MEM_REQ, p1);
    end
    RaccIn = '0;
    step();
    tests_run++;
    if ({RaccOut, mem_if.MEM_REQ} !== {p2, 1'b0}) begin
      tests_failed++;
      $display("FAIL pass_response got out=%h req=%b want out=%h req=0", RaccOut, mem_if.MEM_REQ, p2);
    end
    step();
    tests_run++;
    if ({RaccOut, mem_if.MEM_REQ} !== {{RACC_W{1'b0}}, 1'b0}) begin
      tests_failed++;
      $display("FAIL pass_empty got out=%h req=%b want 0 0", RaccOut, mem_if.MEM_REQ);
    end
  endtask

  task automatic test_busy_retry();
    logic [RACC_W-1:0] b;
    b = pkt(1, 0, 0, 8'h06, 4'hF, 32'h0, 32'h0000_0044);
    RaccIn = pkt(1, 0, 0, 8'h05, 4'hF, 32'h0, 32'h0000_0040);
    step();
    RaccIn = b;
    step();
    RaccIn = '0;
    step();
    tests_run++;
    if ({RaccOut, mem_if.MEM_ADDR, mem_if.MEM_REQ} !== {b, 32'h0000_0040, 1'b1}) begin
      tests_failed++;
      $display("FAIL busy_forward got out=%h addr=%h req=%b want out=%h addr=00000040 req=1",
               RaccOut, mem_if.MEM_ADDR, mem_if.MEM_REQ, b);
    end
    mem_if.MEM_ACK   = 1'b1;
    mem_if.MEM_RDATA = 32'h0BAD_F00D;
    step();
    mem_if.MEM_ACK = 1'b0;
    step();
    tests_run++;
    if (RaccOut !== pkt(1, 0, 1, 8'h05, 4'hF, 32'h0BAD_F00D, 32'h0000_0040)) begin
      tests_failed++;
      $display("FAIL busy_first_resp got %h want %h", RaccOut,
               pkt(1, 0, 1, 8'h05, 4'hF, 32'h0BAD_F00D, 32'h0000_0040));
    end
    step();
  endtask

  task automatic test_slot_contention();
    logic [RACC_W-1:0] f [3];
    f[0] = pkt(1, 0, 0, 8'h21, 4'hF, 32'h0, 32'h0002_0000);
    f[1] = pkt(1, 0, 1, 8'h22, 4'hF, 32'h1111_1111, 32'h0003_0000);
    f[2] = pkt(1, 0, 0, 8'h23, 4'hF, 32'h0, 32'h0000_0060);
    RaccIn = pkt(1, 1, 0, 8'h11, 4'hF, 32'h0102_0304, 32'h0000_0050);
    step();
    RaccIn = '0;
    step();
    mem_if.MEM_ACK = 1'b1;
    RaccIn = f[0];
    step();
    mem_if.MEM_ACK = 1'b0;
    for (int i = 0; i < 3; i++) begin
      RaccIn = (i < 2) ? f[i+1] : '0;
      step();
      tests_run++;
      if ({RaccOut, mem_if.MEM_REQ} !== {f[i], 1'b0}) begin
        tests_failed++;
        $display("FAIL contention_fwd%0d got out=%h req=%b want out=%h req=0", i, RaccOut, mem_if.MEM_REQ, f[i]);
      end
    end
    step();
    tests_run++;
    if (RaccOut !== pkt(1, 1, 1, 8'h11, 4'hF, 32'h0102_0304, 32'h0000_0050)) begin
      tests_failed++;
      $display("FAIL contention_inject got %h want %h", RaccOut,
               pkt(1, 1, 1, 8'h11, 4'hF, 32'h0102_0304, 32'h0000_0050));
    end
    step();
  endtask

  task automatic test_reset_mid_access();
    int seen;
    seen = 0;
    RaccIn = pkt(1, 0, 0, 8'h31, 4'hF, 32'h0, 32'h0000_0070);
    step();
    RaccIn = '0;
    step();
    tests_run++;
    if (mem_if.MEM_REQ !== 1'b1) begin
      tests_failed++;
      $display("FAIL rst_mid_pre_req got %b want 1", mem_if.MEM_REQ);
    end
    RST = 1'b1;
    step();
    RST = 1'b0;
    tests_run++;
    if ({mem_if.MEM_REQ, mem_if.MEM_ADDR, RaccOut} !== {1'b0, 32'h0, {RACC_W{1'b0}}}) begin
      tests_failed++;
      $display("FAIL rst_mid_clear got req=%b addr=%h out=%h want 0 0 0", mem_if.MEM_REQ, mem_if.MEM_ADDR, RaccOut);
    end
    mem_if.MEM_ACK   = 1'b1;
    mem_if.MEM_RDATA = 32'h5A5A_5A5A;
    step();
    mem_if.MEM_ACK = 1'b0;
    for (int i = 0; i < 6; i++) begin
      if (RaccOut !== '0 || mem_if.MEM_REQ !== 1'b0) seen++;
      step();
    end
    tests_run++;
    if (seen !== 0) begin
      tests_failed++;
      $display("FAIL rst_mid_late_ack got %0d nonzero cycles want 0", seen);
    end
  endtask

`ifdef RACCOON_TIMEOUT_EN
  task automatic test_timeout();
    logic got;
    got = 1'b0;
    RaccIn = pkt(1, 0, 0, 8'h41, 4'hF, 32'h0, 32'h0000_0080);
    step();
    RaccIn = '0;
    for (int i = 0; i < 20 && !got; i++) begin
      step();
      if (RaccOut[RACC_VLD] === 1'b1) got = 1'b1;
    end
    tests_run++;
    if (RaccOut !== pkt(1, 0, 1, 8'h41, 4'hF, 32'hDEAD_BEEF, 32'h0000_0080)) begin
      tests_failed++;
      $display("FAIL timeout_resp got %h want %h", RaccOut,
               pkt(1, 0, 1, 8'h41, 4'hF, 32'hDEAD_BEEF, 32'h0000_0080));
    end
    step();
  endtask
`endif

  initial begin
    RST              = 1'b1;
    RaccIn           = '0;
    mem_if.MEM_ACK   = 1'b0;
    mem_if.MEM_RDATA = '0;
    test_reset();
    test_read_hit();
    test_write_hit();
    test_passthrough();
    test_busy_retry();
    test_slot_contention();
    test_reset_mid_access();
`ifdef RACCOON_TIMEOUT_EN
    test_timeout();
`endif
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog got timeout want completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/raccoon_target.md
Name: raccoon_target

Overview:
Raccoon ring responder. It is the target-side counterpart of the Tawas per-thread load/store initiator.
- Registers the incoming 79-bit Raccoon packet and claims requests whose address decodes to its window.
- Performs one access on a simple local memory/register port, then injects the ack response back onto the ring.
- Everything it does not claim is forwarded unchanged with one cycle of latency.
- Sits as one node on the ring, in front of an SRAM or register-file slave.

Parameters:
ADDR_BASE, 32'h0000_0000, window base; claim when (addr & ADDR_MASK) == ADDR_BASE
ADDR_MASK, 32'hFFFF_0000, window decode mask
TIMEOUT, 8'd64, local-port cycles before error response (only with RACCOON_TIMEOUT_EN)

Ports:
CLK  in  1  clock
RST  in  1  synchronous active-high reset
RaccIn  in  79  ring input packet
RaccOut  out  79  ring output packet, registered
MEM_REQ  out  1  local access request, held until MEM_ACK
MEM_WR  out  1  1=write, 0=read
MEM_ADDR  out  32  local address (full packet address)
MEM_MASK  out  4  byte-lane enables
MEM_WDATA  out  32  write data
MEM_ACK  in  1  local completion; sampled only while MEM_REQ=1
MEM_RDATA  in  32  read data, valid with MEM_ACK on reads

Behaviour:
- One clock; reset is synchronous and active-high (CLK, RST).
- Packet fields: [78] vld, [77] wr, [76] ack, [75:68] id, [67:64] mask, [63:32] data, [31:0] addr.
- racc_in: RaccIn registered every edge; cleared to 0 on RST.
- Claim condition: racc_in vld=1, ack=0, address in window, and state IDLE.
- State machine:
  - IDLE -> ACCESS on claim. At the same edge, latch wr/id/mask/data/addr into the pending register, set MEM_REQ=1 with MEM_* driven from the packet, and drive RaccOut=0 (slot consumed).
  - ACCESS: MEM_* held stable. On an edge with MEM_ACK=1: MEM_REQ<=0; on reads, latch MEM_RDATA into pending data (writes keep the write data); go to RESPOND.
  - RESPOND: on the first edge where racc_in vld=0, RaccOut <= {1, wr, 1, id, mask, data, addr}, then go to IDLE.
- Response data is the full 32-bit word. Byte-lane extraction is the initiator's job.
- Forwarding: any racc_in not claimed is copied to RaccOut at the next edge.
  - This covers vld=0, ack=1 responses, out-of-window requests, and in-window requests arriving while busy.
  - A busy-time in-window request therefore circulates back to its initiator as a retry (vld=1, ack=0).
- A response never overwrites a forwarded packet; forwarding has priority over injection.
- Empty slot: RaccOut <= 0 when nothing is forwarded or injected.
- Latency: claimed packet at RaccIn on edge E0 gives MEM_REQ high after E1. With MEM_ACK seen at edge Ek and an empty ring, the response appears on RaccOut after Ek+1.
- Only one outstanding access; no request queue.
- RST in any state: state IDLE, racc_in=0, RaccOut=0, MEM_REQ=0, MEM_WR=0, MEM_ADDR/MASK/WDATA=0, pending register=0. An in-flight local access is abandoned, and the late MEM_ACK is ignored because MEM_REQ=0.
- MEM_ACK while MEM_REQ=0 is ignored.

Optional Feature:
RACCOON_TIMEOUT_EN
- Defined: an 8-bit counter clears on entry to ACCESS and increments each ACCESS cycle. When it reaches TIMEOUT without MEM_ACK:
  - MEM_REQ<=0
  - pending data <= 32'hDEAD_BEEF (reads and writes)
  - state -> RESPOND
  - The response is still ack=1, so the initiator thread unstalls.
- Undefined: no counter; ACCESS waits indefinitely for MEM_ACK.

Decomposition:
- Shared package tawas_raccoon_pkg holds:
  - RACC_W=79 and field position constants (RACC_VLD=78, RACC_WR=77, RACC_ACK=76, RACC_ID_HI/LO=75/68, RACC_MASK_HI/LO=67/64, RACC_DATA_HI/LO=63/32, RACC_ADDR_HI/LO=31/0)
  - state encoding (IDLE/ACCESS/RESPOND)
  - the 32'hDEAD_BEEF error constant
- The initiator module is updated to use the same package.
- No sub-module is needed; the FSM, slot mux and optional timer fit in one module.

Test Plan:
- Read hit: RaccIn={1,0,0,8'h05,4'hF,0,32'h0000_0010}, MEM_ACK one cycle after MEM_REQ with MEM_RDATA=32'h1234_5678 -> MEM_ADDR=0x10, MEM_WR=0; RaccOut={1,0,1,8'h05,4'hF,32'h1234_5678,32'h10} once.
- Write hit: wr=1, mask=4'b0011, data=32'hAAAA_5555, addr=0x24 -> MEM_WR=1, MEM_MASK=3, MEM_WDATA=32'hAAAA_5555; response ack=1 with data 32'hAAAA_5555.
- Out of window / response passthrough: addr=32'h0001_0000, or a hit address with ack=1 -> RaccOut equals RaccIn delayed 2 cycles; MEM_REQ stays 0.
- Busy retry: second in-window request (id 8'h06) arrives during ACCESS -> forwarded unchanged with ack=0; first response is still delivered.
- Slot contention: RESPOND pending while foreign packets arrive for 3 consecutive cycles -> the 3 packets are forwarded intact and the response is injected in the 4th slot.
- Reset mid-ACCESS, then a late MEM_ACK -> MEM_REQ=0, RaccOut=0, no response ever emitted. With RACCOON_TIMEOUT_EN, TIMEOUT=4 and no MEM_ACK -> response data 32'hDEAD_BEEF, ack=1.
